// File: rtl/nibble_serial_adder_ctrl.sv
// ----------------------------------------------------------------------------
// nibble_serial_adder_ctrl
//
// Purpose:
//   This block performs a wide add of W = 4*NIBBLES bits with a single 4-bit
//   adder, processing one nibble per clock, least significant nibble first.
//   The carry-out of each nibble is registered and fed back as the carry-in
//   of the next nibble. The operand side and the result side each use a
//   valid/ready handshake.
//
// Optional feature:
//   Define NIBBLE_ADDER_OVF_EN to add the ovf_o port. It reports two's-
//   complement signed overflow of the W-bit add. It is registered, becomes
//   valid together with out_valid_o, and is held through DONE.
//
// Ports:
//   clk_i        clock; all state updates on the rising edge
//   rst_ni       synchronous active-low reset
//   in_valid_i   operands a_i/b_i/c_i valid
//   in_ready_o   block can accept operands (IDLE only)
//   a_i, b_i     W-bit operands
//   c_i          initial carry-in
//   out_valid_o  result valid (DONE only)
//   out_ready_i  consumer accepts the result
//   sum_o        A + B + c_i modulo 2^W
//   c_o          final carry-out
//   busy_o       high while in RUN
//   ovf_o        signed overflow (only with NIBBLE_ADDER_OVF_EN)
//
// Parameter:
//   NIBBLES      number of 4-bit slices per operand, legal range 1..16
// ----------------------------------------------------------------------------

// Plain 4-bit full adder: the one adder that gets time-multiplexed.
module four_bit_full_adder (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic [4:0] total;

  assign total = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, c_i};
  assign s_o   = total[3:0];
  assign c_o   = total[4];
endmodule

module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [4*NIBBLES-1:0] a_i,
  input  logic [4*NIBBLES-1:0] b_i,
  input  logic                 c_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [4*NIBBLES-1:0] sum_o,
  output logic                 c_o,
`ifdef NIBBLE_ADDER_OVF_EN
  output logic                 ovf_o,
`endif
  output logic                 busy_o
);

  localparam int W  = 4 * NIBBLES;
  // A 1-bit counter is still used when NIBBLES = 1, so no zero-width vectors appear.
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_sh_q, a_sh_d;
  logic [W-1:0]    b_sh_q, b_sh_d;
  logic [W-1:0]    res_q, res_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            c_q, c_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  logic            in_ready_q, in_ready_d;
`ifdef NIBBLE_ADDER_OVF_EN
  logic            ovf_q, ovf_d;
`endif

  logic [3:0]      add_s;
  logic            add_c;

  // The adder is always driven from the low nibble of the shifters. Its
  // result is only captured while in RUN.
  four_bit_full_adder u_adder (
    .a_i (a_sh_q[3:0]),
    .b_i (b_sh_q[3:0]),
    .c_i (carry_q),
    .s_o (add_s),
    .c_o (add_c)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    sum_d   = sum_q;
    c_d     = c_q;
`ifdef NIBBLE_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif

    unique case (state_q)
      IDLE: begin
        // in_ready is high for the whole IDLE state, so in_valid alone accepts the operands.
        if (in_valid_i) begin
          a_sh_d  = a_i;
          b_sh_d  = b_i;
          carry_d = c_i;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // The new nibble enters at the top. After NIBBLES shifts, the first
        // nibble has reached bit 0. This form also works when W = 4.
        res_d           = res_q >> 4;
        res_d[W-1 -: 4] = add_s;
        carry_d         = add_c;
        a_sh_d          = a_sh_q >> 4;
        b_sh_d          = b_sh_q >> 4;
        cnt_d           = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          // Capture into separate output registers, so sum_o/c_o do not
          // change during the next operation's RUN phase.
          state_d = DONE;
          sum_d   = res_d;
          c_d     = add_c;
`ifdef NIBBLE_ADDER_OVF_EN
          // On the last nibble, bit 3 of the shifters holds the operand MSBs.
          ovf_d   = (a_sh_q[3] == b_sh_q[3]) && (add_s[3] != a_sh_q[3]);
`endif
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake outputs are registered copies of the decoded next state.
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == RUN);
    in_ready_d  = (state_d == IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_q       <= '0;
      sum_q       <= '0;
      c_q         <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef NIBBLE_ADDER_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      res_q       <= res_d;
      sum_q       <= sum_d;
      c_q         <= c_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
`ifdef NIBBLE_ADDER_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign sum_o       = sum_q;
  assign c_o         = c_q;
`ifdef NIBBLE_ADDER_OVF_EN
  assign ovf_o       = ovf_q;
`endif

endmodule
